instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage for the single-cycle/pipelined RV32 core. Owns the program counter and drives the address port of the combinational instruction memory. Captures each returned word with its PC into a small FIFO and presents it to decode over a valid/ready handshake. Accepts branch/jump redirects and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  32  address to instruction memory; equals current PC register (combinational from register)
imem_rdata  input  32  instruction word from memory, valid same cycle as imem_addr (zero-latency ROM)
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
instr_valid  output  1  FIFO head holds an instruction
instr_ready  input  1  decode accepts head this cycle
instr  output  32  head instruction word
instr_pc  output  32  PC of head instruction
misalign_err  output  1  sticky: last redirect target had redirect_pc[1:0] != 0

Behaviour:
- Reset (rst high at edge): pc=RESET_PC, FIFO empty, state=RUN, instr_valid=0, instr=0, instr_pc=0, misalign_err=0. Reset mid-stream discards all FIFO contents and any pending redirect.
- States: RUN (fetching), FAULT (halted after misaligned redirect).
- pop = instr_valid && instr_ready.
- push = state==RUN && !redirect_valid && (count<DEPTH || pop). Push writes {pc, imem_rdata}; pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000).
- Simultaneous push and pop on full FIFO allowed; count unchanged.
- Full and no pop: no push, pc holds, imem_addr holds.
- Redirect (redirect_valid high, any state): FIFO flushed this edge (overrides push and pop; a pop presented the same cycle is NOT counted as consumed—decode must ignore it), no push.
  - redirect_pc[1:0]==0: pc <= redirect_pc, state <= RUN, misalign_err <= 0.
  - redirect_pc[1:0]!=0: pc <= redirect_pc, state <= FAULT, misalign_err <= 1.
- FAULT: no pushes; FIFO already empty so instr_valid=0; leave only by aligned redirect or reset.
- Latency: instruction at address X becomes instr_valid the cycle after pc==X is pushed (one cycle from reset release or redirect edge). Throughput one instruction per cycle with instr_ready held high.
- instr/instr_pc reflect head entry; when empty they hold last value (undefined to consumer, reset value 0).
- instr_valid is registered-state derived (count!=0), no combinational path from instr_ready or redirect_valid to instr_valid.
- imem_addr never depends combinationally on redirect_pc.

Test Plan:
- Reset, RESET_PC=0, instr_ready=1, ROM words at 0,4,8 -> instr_valid from cycle 1; instr_pc 0,4,8 on consecutive cycles with matching words; imem_addr advances 0,4,8,12.
- instr_ready=0 for 5 cycles after reset -> FIFO fills to 2 (PCs 0,4), imem_addr stalls at 8; ready=1 -> outputs PCs 0,4,8,... with no gap or duplicate.
- With PCs 0,4 queued, redirect_valid=1 redirect_pc=24 -> next cycle instr_valid=0, imem_addr=24; following cycle instr_pc=24 with ROM word at 24.
- redirect_pc=32'h0000_0012 -> misalign_err=1, instr_valid stays 0, imem_addr frozen at 0x12; later redirect_pc=0x10 -> misalign_err=0, instr_pc=0x10 valid one cycle later.
- Redirect asserted same cycle as pop on full FIFO -> FIFO empty next cycle, no entry from old stream ever appears.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004; assert rst mid-stream -> instr_valid=0 next cycle, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage for the RV32 core. Owns the program counter, drives the
// zero-latency instruction ROM, and queues {pc, word} pairs in a small FIFO
// that decode drains over a valid/ready handshake. A redirect flushes the
// queue; a redirect to a target that is not word aligned parks the unit in
// FAULT with a sticky error flag until an aligned redirect or reset.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    // Pointer width; DEPTH is a power of two and at least 2.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [31:0]   PC_STEP   = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_word [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_misalign;

    logic          w_fetch_en;
    logic          w_pop;
    logic          w_push;
    logic          w_target_misaligned;

    // Fetch enable from the FSM, handshake pop and the push decision.
    always_comb begin
        w_fetch_en          = 1'b0;
        w_pop               = 1'b0;
        w_push              = 1'b0;
        w_target_misaligned = (redirect_pc[1:0] != 2'b00);

        case (r_state)
            ST_RUN:   w_fetch_en = 1'b1;
            ST_FAULT: w_fetch_en = 1'b0;
            default:  w_fetch_en = 1'b0;
        endcase

        if (r_count != CNT_ZERO) begin
            w_pop = instr_ready;
        end else begin
            w_pop = 1'b0;
        end

        // A redirect owns the edge: the stale word at the old pc is never queued.
        if (redirect_valid) begin
            w_push = 1'b0;
        end else if (w_fetch_en && ((r_count < CNT_DEPTH) || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // PC, FSM, error flag and FIFO storage/pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_rd_ptr   <= {AW{1'b0}};
            r_wr_ptr   <= {AW{1'b0}};
            r_count    <= CNT_ZERO;
            r_misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= 32'h0000_0000;
                r_mem_word[i] <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            // Flush by collapsing the write pointer onto the read pointer; a
            // pop offered this cycle is dropped, so decode must discard it.
            r_pc     <= redirect_pc;
            r_wr_ptr <= r_rd_ptr;
            r_count  <= CNT_ZERO;
            if (w_target_misaligned) begin
                r_state    <= ST_FAULT;
                r_misalign <= 1'b1;
            end else begin
                r_state    <= ST_RUN;
                r_misalign <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]   <= r_pc;
                r_mem_word[r_wr_ptr] <= imem_rdata;
                r_wr_ptr             <= r_wr_ptr + PTR_ONE;
                r_pc                 <= r_pc + PC_STEP;
            end else begin
                r_pc <= r_pc;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // All outputs come straight from registers; nothing combinational from
    // redirect_pc, redirect_valid or instr_ready reaches them.
    assign imem_addr    = r_pc;
    assign instr_valid  = (r_count != CNT_ZERO);
    assign instr        = r_mem_word[r_rd_ptr];
    assign instr_pc     = r_mem_pc[r_rd_ptr];
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// Bench for instr_fetch_unit. Two instances share the clock: dut0 with the
// default reset PC and dut1 starting near the top of the address space to
// exercise pc wrap. A queue-based model of the fetch queue tracks both.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RP0   = 32'h0000_0000;
    localparam logic [31:0] RP1   = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_s            [2];
    logic [31:0] imem_addr_s      [2];
    logic [31:0] imem_rdata_s     [2];
    logic        redirect_valid_s [2];
    logic [31:0] redirect_pc_s    [2];
    logic        instr_valid_s    [2];
    logic        instr_ready_s    [2];
    logic [31:0] instr_s          [2];
    logic [31:0] instr_pc_s       [2];
    logic        misalign_err_s   [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of {pc, word}, next fetch pc, halted flag, error flag.
    logic [63:0] m_q     [2][$];
    logic [31:0] m_pc    [2];
    logic        m_fault [2];
    logic        m_mis   [2];

    // Arbitrary but address-unique ROM contents.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata_s[0] = rom(imem_addr_s[0]);
    assign imem_rdata_s[1] = rom(imem_addr_s[1]);

    instr_fetch_unit #(.RESET_PC(RP0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst_s[0]), .imem_addr(imem_addr_s[0]), .imem_rdata(imem_rdata_s[0]),
        .redirect_valid(redirect_valid_s[0]), .redirect_pc(redirect_pc_s[0]),
        .instr_valid(instr_valid_s[0]), .instr_ready(instr_ready_s[0]),
        .instr(instr_s[0]), .instr_pc(instr_pc_s[0]), .misalign_err(misalign_err_s[0])
    );

    instr_fetch_unit #(.RESET_PC(RP1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst_s[1]), .imem_addr(imem_addr_s[1]), .imem_rdata(imem_rdata_s[1]),
        .redirect_valid(redirect_valid_s[1]), .redirect_pc(redirect_pc_s[1]),
        .instr_valid(instr_valid_s[1]), .instr_ready(instr_ready_s[1]),
        .instr(instr_s[1]), .instr_pc(instr_pc_s[1]), .misalign_err(misalign_err_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance both models by one clock from the currently driven inputs, then
    // clock the DUTs and settle 1 time unit past the edge.
    task automatic tick();
        int  sz;
        logic pop;
        for (int d = 0; d < 2; d++) begin
            if (rst_s[d]) begin
                m_q[d].delete();
                m_pc[d]    = (d == 0) ? RP0 : RP1;
                m_fault[d] = 1'b0;
                m_mis[d]   = 1'b0;
            end else begin
                sz  = m_q[d].size();
                pop = (sz != 0) && instr_ready_s[d];
                if (redirect_valid_s[d]) begin
                    m_q[d].delete();
                    m_pc[d]    = redirect_pc_s[d];
                    m_fault[d] = (redirect_pc_s[d][1:0] != 2'b00);
                    m_mis[d]   = m_fault[d];
                end else begin
                    if (pop) void'(m_q[d].pop_front());
                    if (!m_fault[d] && (sz < DEPTH || pop)) begin
                        m_q[d].push_back({m_pc[d], rom(m_pc[d])});
                        m_pc[d] = m_pc[d] + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            instr_ready_s[d] = 1'b0; redirect_valid_s[d] = 1'b0; redirect_pc_s[d] = 32'h0;
        end
        tick(); tick();
        n_cmp++;
        if (instr_valid_s[0] !== 1'b0 || instr_s[0] !== 32'h0 || instr_pc_s[0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs valid=%b instr=%h pc=%h required 0/0/0",
                     instr_valid_s[0], instr_s[0], instr_pc_s[0]);
        end
        n_cmp++;
        if (imem_addr_s[0] !== RP0 || misalign_err_s[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pc addr=%h mis=%b required %h/0", imem_addr_s[0], misalign_err_s[0], RP0);
        end
        n_cmp++;
        if (imem_addr_s[1] !== RP1 || instr_valid_s[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pc_hi addr=%h valid=%b required %h/0", imem_addr_s[1], instr_valid_s[1], RP1);
        end
    endtask

    task automatic test_stream();
        rst_s[0] = 1'b0; instr_ready_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'(4 * i) || instr_s[0] !== rom(32'(4 * i))) begin
                n_err++;
                $display("FAIL stream_head i=%0d valid=%b pc=%h word=%h required 1/%h/%h",
                         i, instr_valid_s[0], instr_pc_s[0], instr_s[0], 32'(4 * i), rom(32'(4 * i)));
            end
            n_cmp++;
            if (imem_addr_s[0] !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL stream_addr i=%0d got %h required %h", i, imem_addr_s[0], 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_backpressure();
        rst_s[0] = 1'b1; tick();
        rst_s[0] = 1'b0; instr_ready_s[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'h0 || imem_addr_s[0] !== 32'h8) begin
            n_err++;
            $display("FAIL bp_full valid=%b pc=%h addr=%h required 1/0/8",
                     instr_valid_s[0], instr_pc_s[0], imem_addr_s[0]);
        end
        instr_ready_s[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'(4 * k) || instr_s[0] !== rom(32'(4 * k))
                || imem_addr_s[0] !== 32'(8 + 4 * k)) begin
                n_err++;
                $display("FAIL bp_drain k=%0d pc=%h word=%h addr=%h required %h/%h/%h",
                         k, instr_pc_s[0], instr_s[0], imem_addr_s[0], 32'(4 * k), rom(32'(4 * k)), 32'(8 + 4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        rst_s[0] = 1'b1; tick();
        rst_s[0] = 1'b0; instr_ready_s[0] = 1'b0;
        tick(); tick();
        redirect_valid_s[0] = 1'b1; redirect_pc_s[0] = 32'd24;
        tick();
        redirect_valid_s[0] = 1'b0;
        n_cmp++;
        if (instr_valid_s[0] !== 1'b0 || imem_addr_s[0] !== 32'd24) begin
            n_err++;
            $display("FAIL redir_flush valid=%b addr=%h required 0/18", instr_valid_s[0], imem_addr_s[0]);
        end
        tick();
        n_cmp++;
        if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'd24 || instr_s[0] !== rom(32'd24)) begin
            n_err++;
            $display("FAIL redir_target valid=%b pc=%h word=%h required 1/18/%h",
                     instr_valid_s[0], instr_pc_s[0], instr_s[0], rom(32'd24));
        end
    endtask

    task automatic test_misalign();
        redirect_valid_s[0] = 1'b1; redirect_pc_s[0] = 32'h0000_0012;
        tick();
        redirect_valid_s[0] = 1'b0;
        n_cmp++;
        if (misalign_err_s[0] !== 1'b1 || instr_valid_s[0] !== 1'b0 || imem_addr_s[0] !== 32'h12) begin
            n_err++;
            $display("FAIL mis_set mis=%b valid=%b addr=%h required 1/0/12",
                     misalign_err_s[0], instr_valid_s[0], imem_addr_s[0]);
        end
        instr_ready_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (misalign_err_s[0] !== 1'b1 || instr_valid_s[0] !== 1'b0 || imem_addr_s[0] !== 32'h12) begin
                n_err++;
                $display("FAIL mis_hold i=%0d mis=%b valid=%b addr=%h required 1/0/12",
                         i, misalign_err_s[0], instr_valid_s[0], imem_addr_s[0]);
            end
        end
        redirect_valid_s[0] = 1'b1; redirect_pc_s[0] = 32'h0000_0010;
        tick();
        redirect_valid_s[0] = 1'b0;
        n_cmp++;
        if (misalign_err_s[0] !== 1'b0 || instr_valid_s[0] !== 1'b0 || imem_addr_s[0] !== 32'h10) begin
            n_err++;
            $display("FAIL mis_clear mis=%b valid=%b addr=%h required 0/0/10",
                     misalign_err_s[0], instr_valid_s[0], imem_addr_s[0]);
        end
        tick();
        n_cmp++;
        if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'h10 || instr_s[0] !== rom(32'h10)) begin
            n_err++;
            $display("FAIL mis_resume valid=%b pc=%h required 1/10", instr_valid_s[0], instr_pc_s[0]);
        end
    endtask

    task automatic test_redirect_pop();
        rst_s[0] = 1'b1; tick();
        rst_s[0] = 1'b0; instr_ready_s[0] = 1'b0;
        tick(); tick();
        instr_ready_s[0] = 1'b1; redirect_valid_s[0] = 1'b1; redirect_pc_s[0] = 32'h40;
        tick();
        redirect_valid_s[0] = 1'b0;
        n_cmp++;
        if (instr_valid_s[0] !== 1'b0 || imem_addr_s[0] !== 32'h40) begin
            n_err++;
            $display("FAIL rpop_flush valid=%b addr=%h required 0/40", instr_valid_s[0], imem_addr_s[0]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (instr_valid_s[0] !== 1'b1 || instr_pc_s[0] !== 32'(32'h40 + 4 * k)) begin
                n_err++;
                $display("FAIL rpop_seq k=%0d valid=%b pc=%h required 1/%h",
                         k, instr_valid_s[0], instr_pc_s[0], 32'(32'h40 + 4 * k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b0; instr_ready_s[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            e = RP1 + 32'(4 * k);
            n_cmp++;
            if (instr_valid_s[1] !== 1'b1 || instr_pc_s[1] !== e || instr_s[1] !== rom(e)) begin
                n_err++;
                $display("FAIL wrap_seq k=%0d valid=%b pc=%h word=%h required 1/%h/%h",
                         k, instr_valid_s[1], instr_pc_s[1], instr_s[1], e, rom(e));
            end
        end
        rst_s[1] = 1'b1;
        tick();
        n_cmp++;
        if (instr_valid_s[1] !== 1'b0 || imem_addr_s[1] !== RP1 || instr_pc_s[1] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_midreset valid=%b addr=%h pc=%h required 0/%h/0",
                     instr_valid_s[1], imem_addr_s[1], instr_pc_s[1], RP1);
        end
    endtask

    task automatic test_random();
        logic [63:0] h;
        logic        ev;
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                rst_s[d]            = ($urandom_range(63) == 0);
                instr_ready_s[d]    = ($urandom_range(3) != 0);
                redirect_valid_s[d] = ($urandom_range(7) == 0);
                redirect_pc_s[d]    = {$urandom, 2'b00} ^ (($urandom_range(3) == 0) ? 32'(($urandom_range(2)) + 1) : 32'h0);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                ev = (m_q[d].size() != 0);
                n_cmp++;
                if (instr_valid_s[d] !== ev || imem_addr_s[d] !== m_pc[d] || misalign_err_s[d] !== m_mis[d]) begin
                    n_err++;
                    $display("FAIL rnd_state dut%0d cyc%0d valid=%b addr=%h mis=%b required %b/%h/%b",
                             d, c, instr_valid_s[d], imem_addr_s[d], misalign_err_s[d], ev, m_pc[d], m_mis[d]);
                end
                if (ev) begin
                    h = m_q[d][0];
                    n_cmp++;
                    if (instr_pc_s[d] !== h[63:32] || instr_s[d] !== h[31:0]) begin
                        n_err++;
                        $display("FAIL rnd_head dut%0d cyc%0d pc=%h word=%h required %h/%h",
                                 d, c, instr_pc_s[d], instr_s[d], h[63:32], h[31:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_redirect_pop();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
